// File: rtl/glm_op_dispatch_pkg.sv
// Shared types and constants for the GLM operator dispatcher: FSM states,
// the latched instruction record and the sticky error bit positions.
package glm_dispatch_pkg;

    localparam int GLM_NUM_UNITS = 4;
    localparam int GLM_NUM_REGS  = 5;
    localparam int GLM_REGS_W    = 32 * GLM_NUM_REGS;
    // Wide enough for the unit-select field of the largest legal array (16 units).
    localparam int GLM_UNIT_FW   = 5;

    localparam int ERR_BAD_UNIT      = 0;
    localparam int ERR_SPURIOUS_DONE = 1;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } t_dispatch_state;

    typedef struct packed {
        logic [GLM_UNIT_FW-1:0] unit;
        logic                   sync;
        logic [GLM_REGS_W-1:0]  regs;
    } t_glm_instr;

endpackage

// File: rtl/glm_busy_tracker.sv
// Per-unit busy bits for the GLM dispatcher: set on start, cleared on a
// matching done, with spurious-done detection and a popcount of accepted dones.
module glm_busy_tracker #(
    parameter  int NUM_UNITS = 4,
    localparam int CNT_W     = $clog2(NUM_UNITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_UNITS-1:0] i_start,
    input  logic [NUM_UNITS-1:0] i_done,
    output logic [NUM_UNITS-1:0] o_busy,
    output logic                 o_spurious,
    output logic [CNT_W-1:0]     o_done_pop
);

    logic [NUM_UNITS-1:0] r_busy;
    logic [NUM_UNITS-1:0] w_accept;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_UNITS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // A done only counts against a unit that is currently busy.
    assign w_accept   = i_done & r_busy;
    assign o_spurious = |(i_done & ~r_busy);
    assign o_done_pop = popcount(w_accept);
    assign o_busy     = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_accept) | i_start;
        end
    end

endmodule

// File: rtl/glm_op_dispatch.sv
// Issues queued GLM instructions to operator units, never restarting a busy unit
// and honouring a sync barrier. Optional stall counters: GLM_DISPATCH_PERFCNT_EN.
module glm_op_dispatch
    import glm_dispatch_pkg::*;
#(
    parameter  int NUM_UNITS = GLM_NUM_UNITS,
    parameter  int NUM_REGS  = GLM_NUM_REGS,
    localparam int UNIT_W    = $clog2(NUM_UNITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [UNIT_W:0]       instr_unit,
    input  logic                  instr_sync,
    input  logic [32*NUM_REGS-1:0] instr_regs,
    output logic [NUM_UNITS-1:0]  op_start,
    output logic [32*NUM_REGS-1:0] op_regs,
    input  logic [NUM_UNITS-1:0]  op_done,
    output logic [NUM_UNITS-1:0]  unit_busy,
    output logic                  all_idle,
    output logic [1:0]            err,
    output logic [31:0]           issued_count,
    output logic [31:0]           done_count
`ifdef GLM_DISPATCH_PERFCNT_EN
    ,
    output logic [31:0]           stall_busy_cycles,
    output logic [31:0]           stall_sync_cycles
`endif
);

    localparam int                   REGS_W     = 32 * NUM_REGS;
    localparam int                   CNT_W      = $clog2(NUM_UNITS + 1);
    localparam logic [UNIT_W:0]      UNIT_LIMIT = (UNIT_W + 1)'(NUM_UNITS);
    localparam logic [NUM_UNITS-1:0] UNIT_ONE   = NUM_UNITS'(1);

    t_dispatch_state      r_state;
    t_glm_instr           r_instr;
    logic [NUM_UNITS-1:0] r_op_start;
    logic [REGS_W-1:0]    r_op_regs;
    logic [1:0]           r_err;
    logic [31:0]          r_issued;
    logic [31:0]          r_done_cnt;

    logic [NUM_UNITS-1:0] w_busy;
    logic [NUM_UNITS-1:0] w_sel;
    logic [NUM_UNITS-1:0] w_start;
    logic                 w_sel_busy;
    logic                 w_barrier;
    logic                 w_stall;
    logic                 w_issue;
    logic                 w_bad_unit;
    logic                 w_spurious;
    logic [CNT_W-1:0]     w_done_pop;

    // Stall decisions use the registered busy vector; a done in a stall cycle
    // only frees the unit for the following cycle.
    assign w_sel      = UNIT_ONE << r_instr.unit;
    assign w_sel_busy = |(w_busy & w_sel);
    assign w_barrier  = r_instr.sync && (|w_busy);
    assign w_stall    = w_barrier || w_sel_busy;
    assign w_issue    = (r_state == S_ISSUE) && !w_stall;
    assign w_start    = w_issue ? w_sel : '0;
    assign w_bad_unit = (instr_unit >= UNIT_LIMIT);

    glm_busy_tracker #(
        .NUM_UNITS (NUM_UNITS)
    ) u_busy (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_start),
        .i_done     (op_done),
        .o_busy     (w_busy),
        .o_spurious (w_spurious),
        .o_done_pop (w_done_pop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_op_start <= '0;
            r_op_regs  <= '0;
            r_err      <= '0;
            r_issued   <= '0;
            r_done_cnt <= '0;
        end else begin
            r_op_start <= '0;
            r_done_cnt <= r_done_cnt + 32'(w_done_pop);
            if (w_spurious) begin
                r_err[ERR_SPURIOUS_DONE] <= 1'b1;
            end
            case (r_state)
                S_FETCH: begin
                    if (instr_valid) begin
                        if (w_bad_unit) begin
                            r_err[ERR_BAD_UNIT] <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_op_start <= w_sel;
                        r_op_regs  <= REGS_W'(r_instr.regs);
                        r_issued   <= r_issued + 32'd1;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Instruction payload is plain data; it is only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        if ((r_state == S_FETCH) && instr_valid && !w_bad_unit) begin
            r_instr.unit <= GLM_UNIT_FW'(instr_unit);
            r_instr.sync <= instr_sync;
            r_instr.regs <= GLM_REGS_W'(instr_regs);
        end
    end

`ifdef GLM_DISPATCH_PERFCNT_EN
    logic [31:0] r_stall_busy;
    logic [31:0] r_stall_sync;

    // When both block conditions hold, the cycle is charged to the barrier.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_busy <= '0;
            r_stall_sync <= '0;
        end else if (r_state == S_ISSUE) begin
            if (w_barrier) begin
                r_stall_sync <= r_stall_sync + 32'd1;
            end else if (w_sel_busy) begin
                r_stall_busy <= r_stall_busy + 32'd1;
            end
        end
    end

    assign stall_busy_cycles = r_stall_busy;
    assign stall_sync_cycles = r_stall_sync;
`endif

    assign instr_ready  = (r_state == S_FETCH) && !reset;
    assign all_idle     = (w_busy == '0) && (r_state == S_FETCH) && !instr_valid;
    assign op_start     = r_op_start;
    assign op_regs      = r_op_regs;
    assign unit_busy    = w_busy;
    assign err          = r_err;
    assign issued_count = r_issued;
    assign done_count   = r_done_cnt;

endmodule
